// File: rtl/cal_fifo_drain_arbiter.sv
// Round-robin burst drain of NCH FWFT FIFOs into one framed valid/ready stream.
// Optional CAL_DRAIN_WATERMARK_EN: requests require !fifo_aempty, with a 256-cycle fallback.
module cal_fifo_drain_arbiter #(
   parameter int NCH       = 4,
   parameter int DW        = 32,
   parameter int BURST_LEN = 16,
   parameter int CW        = 2
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic              enable,
   input  logic [NCH-1:0]    fifo_empty,
   input  logic [NCH-1:0]    fifo_aempty,
   input  logic [NCH*DW-1:0] fifo_dout,
   output logic [NCH-1:0]    fifo_rd_en,
   output logic [DW-1:0]     m_data,
   output logic [CW-1:0]     m_chan,
   output logic              m_sop,
   output logic              m_eop,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              busy,
   output logic [15:0]       pkt_cnt
);

   localparam int BCW = $clog2(BURST_LEN + 1);

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_BURST, S_DRAIN} state_t;

   state_t          state;
   logic [CW-1:0]   ptr;
   logic [CW-1:0]   grant;
   logic [BCW-1:0]  burst_cnt;
   logic            first_p0;
   logic            vld_p0;
   logic [DW-1:0]   data_p0;
   logic            vld_p1;
   logic [DW-1:0]   data_p1;
   logic [CW-1:0]   chan_p1;
   logic            sop_p1;
   logic            eop_p1;

   logic [NCH-1:0]  req;
   logic            arb_hit;
   logic [CW-1:0]   arb_sel;
   logic [DW-1:0]   dout_sel;
   logic            out_free;
   logic            move;
   logic            pop;
   logic            eop_now;

`ifdef CAL_DRAIN_WATERMARK_EN
   logic [8:0] wait_cnt;

   // wait_cnt[8] marks 256 cycles of data waiting below the watermark
   assign req = wait_cnt[8] ? ~fifo_empty : (~fifo_empty & ~fifo_aempty);

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         wait_cnt <= '0;
      end else if ((state == S_ARB && enable && arb_hit) || (&fifo_empty)) begin
         wait_cnt <= '0;
      end else if ((state == S_IDLE || state == S_ARB) && !wait_cnt[8]) begin
         wait_cnt <= wait_cnt + 9'd1;
      end
   end
`else
   logic unused_aempty;

   assign req          = ~fifo_empty;
   assign unused_aempty = ^fifo_aempty;
`endif

   always_comb begin
      logic [CW-1:0] idx;
      idx     = '0;
      arb_hit = 1'b0;
      arb_sel = '0;
      for (int i = 1; i <= NCH; i++) begin
         idx = CW'((int'(ptr) + i) % NCH);
         if (!arb_hit && req[idx]) begin
            arb_hit = 1'b1;
            arb_sel = idx;
         end
      end
   end

   always_comb begin
      dout_sel = '0;
      for (int k = 0; k < NCH; k++) begin
         if (grant == CW'(k)) dout_sel = fifo_dout[k*DW +: DW];
      end
   end

   assign out_free = !vld_p1 || m_ready;
   assign move     = vld_p0 && out_free;
   assign pop      = (state == S_BURST) && !fifo_empty[grant] && (!vld_p0 || out_free)
                     && (burst_cnt < BCW'(BURST_LEN));
   // When the held word leaves, nothing follows it if the burst is full or the FIFO ran dry
   assign eop_now  = (burst_cnt == BCW'(BURST_LEN)) || fifo_empty[grant];

   always_comb begin
      fifo_rd_en = '0;
      if (pop) fifo_rd_en[grant] = 1'b1;
   end

   // Stage p0: hold register fed straight from the granted FIFO
   always_ff @(posedge clk) begin
      if (pop) data_p0 <= dout_sel;
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= S_IDLE;
         ptr       <= CW'(NCH - 1);
         grant     <= '0;
         busy      <= 1'b0;
         burst_cnt <= '0;
         first_p0  <= 1'b0;
         vld_p0    <= 1'b0;
         vld_p1    <= 1'b0;
         data_p1   <= '0;
         chan_p1   <= '0;
         sop_p1    <= 1'b0;
         eop_p1    <= 1'b0;
         pkt_cnt   <= '0;
      end else begin
         // Stage p1: output register, only reloaded once its word is gone
         if (vld_p1 && m_ready) vld_p1 <= 1'b0;
         if (move) begin
            vld_p1   <= 1'b1;
            data_p1  <= data_p0;
            chan_p1  <= grant;
            sop_p1   <= first_p0;
            eop_p1   <= eop_now;
            first_p0 <= 1'b0;
         end

         if (pop)       vld_p0 <= 1'b1;
         else if (move) vld_p0 <= 1'b0;

         if (pop) burst_cnt <= burst_cnt + 1'b1;

         case (state)
            S_IDLE: begin
               if (enable) state <= S_ARB;
            end
            S_ARB: begin
               if (enable && arb_hit) begin
                  grant     <= arb_sel;
                  ptr       <= arb_sel;
                  busy      <= 1'b1;
                  burst_cnt <= '0;
                  first_p0  <= 1'b1;
                  state     <= S_BURST;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_BURST: begin
               if (move && eop_now) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (vld_p1 && m_ready && eop_p1) begin
                  busy    <= 1'b0;
                  pkt_cnt <= pkt_cnt + 16'd1;
                  state   <= enable ? S_ARB : S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign m_valid = vld_p1;
   assign m_data  = data_p1;
   assign m_chan  = chan_p1;
   assign m_sop   = sop_p1;
   assign m_eop   = eop_p1;

endmodule

// File: tb/tb_cal_fifo_drain_arbiter.sv
// Randomised bench for cal_fifo_drain_arbiter against a packet-level round-robin model.
module tb_cal_fifo_drain_arbiter;
   localparam int NCH = 4, DW = 32, BL = 16, CW = 2, DEPTH = 64;

   logic              clk;
   logic              aresetn;
   logic              enable;
   logic [NCH-1:0]    fifo_empty;
   logic [NCH-1:0]    fifo_aempty;
   logic [NCH*DW-1:0] fifo_dout;
   logic [NCH-1:0]    fifo_rd_en;
   logic [DW-1:0]     m_data;
   logic [CW-1:0]     m_chan;
   logic              m_sop, m_eop, m_valid, m_ready, busy;
   logic [15:0]       pkt_cnt;

   cal_fifo_drain_arbiter #(.NCH(NCH), .DW(DW), .BURST_LEN(BL), .CW(CW)) dut (
      .clk(clk), .aresetn(aresetn), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_aempty(fifo_aempty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
      .m_data(m_data), .m_chan(m_chan), .m_sop(m_sop), .m_eop(m_eop),
      .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .pkt_cnt(pkt_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] d; logic [CW-1:0] ch; logic sop; logic eop; } beat_t;
   beat_t       exp_q[$];
   logic [31:0] fmem [NCH][DEPTH];
   int          rd_ptr[NCH], wr_ptr[NCH], mrem[NCH], mpos[NCH];
   int          mptr, exp_pkts, n_cmp, n_err, ready_pct, ncyc, npop, nacc;
   int          first_pop, first_valid, t0;
   logic [NCH-1:0] pend_pop;
   logic        pend_acc, prev_stall, aempty_force;
   logic [31:0] prev_data;
   logic [CW-1:0] prev_chan;
   logic        prev_sop, prev_eop;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, ncyc);
      end
   endtask

   task automatic drive_fifos();
      for (int k = 0; k < NCH; k++) begin
         fifo_empty[k]        = !(rd_ptr[k] < wr_ptr[k]);
         fifo_dout[k*DW +: DW] = (rd_ptr[k] < wr_ptr[k]) ? fmem[k][rd_ptr[k]] : 32'h0;
      end
      fifo_aempty = aempty_force ? '1 : '0;
   endtask

   // One clock: observe at the falling edge, apply FIFO pops and new inputs just after the rising edge
   task automatic tick();
      beat_t b;
      @(negedge clk);
      ncyc++;
      pend_acc = 1'b0;
      if (!aresetn) begin
         pend_pop   = '0;
         prev_stall = 1'b0;
      end else begin
         if (fifo_rd_en != '0) chk("rd_en_onehot", 32'($countones(fifo_rd_en)), 1);
         if (busy) chk("inflight_le2", 32'((npop - nacc) <= 2), 1);
         if (prev_stall) begin
            chk("stall_valid", 32'(m_valid), 1);
            chk("stall_data", m_data, prev_data);
            chk("stall_ctl", {m_chan, m_sop, m_eop}, {prev_chan, prev_sop, prev_eop});
         end
         if (m_valid && m_ready) begin
            pend_acc = 1'b1;
            if (exp_q.size() == 0) begin
               chk("extra_beat", m_data, 32'hDEAD_BEEF);
            end else begin
               b = exp_q.pop_front();
               chk("data", m_data, b.d);
               chk("chan", 32'(m_chan), 32'(b.ch));
               chk("sop", 32'(m_sop), 32'(b.sop));
               chk("eop", 32'(m_eop), 32'(b.eop));
            end
         end
         if (first_pop < 0 && fifo_rd_en != '0) first_pop = ncyc;
         if (first_valid < 0 && m_valid) first_valid = ncyc;
         pend_pop   = fifo_rd_en;
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_chan  = m_chan;
         prev_sop   = m_sop;
         prev_eop   = m_eop;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NCH; k++) begin
         if (pend_pop[k]) begin
            if (rd_ptr[k] < wr_ptr[k]) rd_ptr[k]++;
            npop++;
         end
      end
      if (pend_acc) nacc++;
      m_ready = ($urandom_range(99) < ready_pct);
      drive_fifos();
   endtask

   task automatic load(input int ch, input int n, input logic [31:0] base, input bit rnd);
      for (int j = 0; j < n; j++) fmem[ch][j] = rnd ? $urandom : base + 32'(j);
      rd_ptr[ch] = 0;
      wr_ptr[ch] = n;
      mrem[ch]   = n;
      mpos[ch]   = 0;
   endtask

   // Packet-level reference: round-robin from the last granted channel, min(BL, remaining) words each
   task automatic model_run(input int max_pkts);
      int  c, len;
      bit  found;
      beat_t b;
      for (int p = 0; p < max_pkts; p++) begin
         found = 0;
         c     = 0;
         for (int i = 1; i <= NCH; i++) begin
            if (!found && mrem[(mptr + i) % NCH] > 0) begin
               found = 1;
               c     = (mptr + i) % NCH;
            end
         end
         if (!found) break;
         len = (mrem[c] < BL) ? mrem[c] : BL;
         for (int j = 0; j < len; j++) begin
            b.d   = fmem[c][mpos[c] + j];
            b.ch  = CW'(c);
            b.sop = (j == 0);
            b.eop = (j == len - 1);
            exp_q.push_back(b);
         end
         mpos[c] += len;
         mrem[c] -= len;
         mptr     = c;
         exp_pkts++;
      end
   endtask

   task automatic clear_all();
      for (int k = 0; k < NCH; k++) begin
         rd_ptr[k] = 0; wr_ptr[k] = 0; mrem[k] = 0; mpos[k] = 0;
      end
      exp_q.delete();
      mptr     = NCH - 1;
      exp_pkts = 0;
      npop     = 0;
      nacc     = 0;
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      enable  = 1'b0;
      clear_all();
      repeat (2) tick();
      aresetn = 1'b1;
      tick();
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit done;
      done = 0;
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0 && !busy) begin
            done = 1;
            break;
         end
         tick();
      end
      chk({tag, "_done"}, 32'(done), 1);
      repeat (8) tick();
   endtask

   task automatic wait_acc(input int n);
      bit hit;
      hit = 0;
      for (int i = 0; i < 500; i++) begin
         if (nacc >= n) begin
            hit = 1;
            break;
         end
         tick();
      end
      chk("wait_acc", 32'(hit), 1);
   endtask

   initial begin
      n_cmp = 0; n_err = 0; ncyc = 0; ready_pct = 100;
      aresetn = 1'b0; enable = 1'b0; m_ready = 1'b0; aempty_force = 1'b0;
      pend_pop = '0; pend_acc = 1'b0; prev_stall = 1'b0;
      prev_data = '0; prev_chan = '0; prev_sop = 1'b0; prev_eop = 1'b0;
      first_pop = -1; first_valid = -1; t0 = 0;
      clear_all();
      drive_fifos();
      do_reset();
      chk("rst_valid", 32'(m_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
      chk("rst_rd_en", 32'(fifo_rd_en), 0);
      chk("rst_data", m_data, 0);
      chk("rst_ctl", {m_chan, m_sop, m_eop}, 0);

      // ch2 holds 20 sequential words: 16-word packet then 4-word packet
      load(2, 20, 32'h100, 0);
      model_run(100);
      enable = 1'b1;
      wait_done("single_ch", 300);
      chk("single_ch_pkts", 32'(pkt_cnt), 32'(exp_pkts));
      chk("single_ch_pkts2", 32'(pkt_cnt), 2);

      // All channels full: order ch0, ch1, ch2, ch3
      do_reset();
      for (int k = 0; k < NCH; k++) load(k, 16, 32'h0, 1);
      model_run(100);
      enable = 1'b1;
      wait_done("round_robin", 400);
      chk("rr_pkts", 32'(pkt_cnt), 32'(exp_pkts));

      // Random fills under 30% m_ready
      ready_pct = 30;
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < NCH; k++) load(k, (r == 0) ? $urandom_range(40, 16) : $urandom_range(40), 32'h0, 1);
         model_run(100);
         wait_done("backpressure", 3000);
         chk("bp_pkts", 32'(pkt_cnt), 32'(exp_pkts));
      end

      // Single-word burst on ch1
      ready_pct   = 100;
      first_pop   = -1;
      first_valid = -1;
      load(1, 1, 32'hABCD, 0);
      model_run(100);
      wait_done("single_word", 100);
      chk("pop_to_valid", 32'(first_valid - first_pop), 2);
      chk("single_word_pkts", 32'(pkt_cnt), 32'(exp_pkts));

      // enable dropped after 5 words: burst completes at 16, then idle
      nacc = 0; npop = 0;
      load(0, 40, 32'h0, 1);
      load(1, 10, 32'h0, 1);
      model_run(1);
      wait_acc(5);
      enable = 1'b0;
      wait_done("disable", 200);
      repeat (10) tick();
      chk("disable_ch0_left", 32'(wr_ptr[0] - rd_ptr[0]), 24);
      chk("disable_ch1_left", 32'(wr_ptr[1] - rd_ptr[1]), 10);
      chk("disable_busy", 32'(busy), 0);
      chk("disable_pkts", 32'(pkt_cnt), 32'(exp_pkts));
      for (int k = 0; k < NCH; k++) begin
         rd_ptr[k] = wr_ptr[k];
         mrem[k]   = 0;
      end

      // aresetn pulsed mid-burst: outputs and pkt_cnt clear
      nacc = 0; npop = 0;
      enable = 1'b1;
      load(3, 20, 32'h0, 1);
      model_run(100);
      wait_acc(5);
      aresetn = 1'b0;
      tick();
      chk("mid_rst_valid", 32'(m_valid), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_pkt_cnt", 32'(pkt_cnt), 0);
      chk("mid_rst_rd_en", 32'(fifo_rd_en), 0);
      chk("mid_rst_data", m_data, 0);
      chk("mid_rst_ctl", {m_chan, m_sop, m_eop}, 0);
      do_reset();

`ifdef CAL_DRAIN_WATERMARK_EN
      // Below watermark: held off ~256 cycles, then flushed as one short packet
      aempty_force = 1'b1;
      first_pop    = -1;
      t0           = ncyc;
      enable       = 1'b1;
      load(0, 3, 32'h0, 1);
      model_run(100);
      wait_done("watermark", 400);
      chk("wm_holdoff", 32'((first_pop - t0) >= 255), 1);
      chk("wm_fallback", 32'((first_pop - t0) <= 270), 1);
      chk("wm_pkts", 32'(pkt_cnt), 32'(exp_pkts));
      aempty_force = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
